alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one alu instance between two requesters, e.g. the integer execute path (req 0) and the branch-compare path (req 1).
//  Arbitrates round-robin, drives the alu operand/control inputs combinationally from the granted request,
//  and registers aluout/eq into a one-entry response slot per requester with valid/ready handshake.
// PARAMETERS
//  D_WIDTH  32  operand/result width; must match the connected alu
// PORTS
//  clk        in   1            rising-edge clock
//  rst        in   1            asynchronous, active-high reset
//  req_valid  in   2            bit i: requester i presents an op
//  req_ready  out  2            bit i: op of requester i accepted this cycle (== grant)
//  req_ctrl   in   8            [4i+3:4i] aluctrl code of requester i
//  req_src    in   2            bit i: alusrc of requester i (1 = imm operand)
//  req_op1    in   2*D_WIDTH    slice i: aluop1 of requester i
//  req_imm    in   2*D_WIDTH    slice i: immop of requester i
//  req_reg    in   2*D_WIDTH    slice i: regop2 of requester i
//  rsp_valid  out  2            bit i: result slot i holds a result
//  rsp_ready  in   2            bit i: requester i consumes its result
//  rsp_data   out  2*D_WIDTH    slice i: registered aluout for requester i
//  rsp_eq     out  2            bit i: registered eq for requester i
//  alusrc     out  1            to alu
//  aluctrl    out  4            to alu
//  aluop1     out  D_WIDTH      to alu
//  immop      out  D_WIDTH      to alu
//  regop2     out  D_WIDTH      to alu
//  aluout     in   D_WIDTH      from alu
//  eq         in   1            from alu
// BEHAVIOUR
//  - Eligible[i] = req_valid[i] && (!rsp_valid[i] || rsp_ready[i]) (slot empty or draining this cycle).
//  - At most one grant per cycle; req_ready one-hot or zero; purely combinational from inputs + state.
//  - Round-robin: state last_gnt (1 bit). Both eligible -> grant ~last_gnt. One eligible -> grant it. last_gnt <= granted index on any grant; unchanged otherwise.
//  - No grant: alu inputs driven from requester last_gnt (don't-care, but stable, no X).
//  - Latency 1: on grant i, at next edge rsp_data[i] <= aluout, rsp_eq[i] <= eq, rsp_valid[i] <= 1.
//  - rsp_valid[i] clears on rsp_valid[i] && rsp_ready[i] unless slot i is re-granted same cycle (re-grant wins: stays 1, new data).
//  - rsp_data/rsp_eq hold when not granted; response slot for requester j is unaffected by grants to i != j.
//  - Requester must hold req_* stable while req_valid=1 and req_ready=0; arbiter never drops a presented op.
//  - Reset (async, any time, including with results pending): rsp_valid=0, rsp_data=0, rsp_eq=0, last_gnt=1 (so requester 0 wins first tie); pending results are discarded; req_ready follows comb rule from reset state.
//  - No internal width growth; result width = D_WIDTH as produced by alu.
// CONFIGURATION
//  ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both eligible; last_gnt still tracked but unused for tie-break.
//  Not defined (default): round-robin as above.
// TESTING
//  1 Reset: assert rst mid-run with rsp_valid=2'b11 -> immediately rsp_valid=0, rsp_data=0, rsp_eq=0, req_ready=0 while rst high and req_valid=0.
//  2 Single op: req 0 ctrl=0000 src=0 op1=5 reg=7 -> req_ready=01 same cycle; next cycle rsp_valid[0]=1, rsp_data[0]=12.
//  3 Tie: both valid continuously, rsp_ready=11 -> grants 0,1,0,1...; req1 op SUB 9-4 yields rsp_data[1]=5.
//  4 Backpressure: rsp_valid[0]=1, rsp_ready[0]=0, both requesting -> only req 1 granted; raise rsp_ready[0] -> req 0 granted same cycle, rsp_valid[0] stays 1 with new data.
//  5 Branch compare: req1 ctrl=0010 op1=-1 reg=1 -> rsp_eq[1]=1, rsp_data[1]=1; ctrl=0011 same operands -> rsp_data[1]=0.
//  6 With ALU_ARB_FIXED_PRIO_EN: both valid, rsp_ready=11 for 4 cycles -> req_ready=01 every cycle, req 1 starved.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one alu between two requesters with registered response slots
// Define ALU_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of alternating.
module alu_arbiter #(
  parameter int D_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [7:0]           req_ctrl,
  input  logic [1:0]           req_src,
  input  logic [2*D_WIDTH-1:0] req_op1,
  input  logic [2*D_WIDTH-1:0] req_imm,
  input  logic [2*D_WIDTH-1:0] req_reg,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [2*D_WIDTH-1:0] rsp_data,
  output logic [1:0]           rsp_eq,
  output logic                 alusrc,
  output logic [3:0]           aluctrl,
  output logic [D_WIDTH-1:0]   aluop1,
  output logic [D_WIDTH-1:0]   immop,
  output logic [D_WIDTH-1:0]   regop2,
  input  logic [D_WIDTH-1:0]   aluout,
  input  logic                 eq
);

  logic       last_gnt;
  logic [1:0] eligible;
  logic [1:0] grant;
  logic       sel;

  // A requester may issue only if its slot is empty or is being drained this cycle.
  always_comb begin
    eligible = req_valid & (~rsp_valid | rsp_ready);
    grant    = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        grant = 2'b01;
`else
        grant = last_gnt ? 2'b01 : 2'b10;
`endif
      end
      default: grant = 2'b00;
    endcase
  end

  // With no grant the alu still sees the last winner's inputs so they stay defined.
  always_comb begin
    sel = grant[1] | (~grant[0] & last_gnt);
  end

  assign req_ready = grant;

  always_comb begin
    if (sel) begin
      alusrc  = req_src[1];
      aluctrl = req_ctrl[7:4];
      aluop1  = req_op1[2*D_WIDTH-1:D_WIDTH];
      immop   = req_imm[2*D_WIDTH-1:D_WIDTH];
      regop2  = req_reg[2*D_WIDTH-1:D_WIDTH];
    end else begin
      alusrc  = req_src[0];
      aluctrl = req_ctrl[3:0];
      aluop1  = req_op1[D_WIDTH-1:0];
      immop   = req_imm[D_WIDTH-1:0];
      regop2  = req_reg[D_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
    end else if (|grant) begin
      last_gnt <= grant[1];
    end
  end

  // A re-grant in the same cycle as a drain keeps the slot full with the new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_eq    <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (grant[i]) begin
          rsp_valid[i]                <= 1'b1;
          rsp_data[i*D_WIDTH +: D_WIDTH] <= aluout;
          rsp_eq[i]                   <= eq;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a small alu stub
module tb_alu_arbiter;
  localparam int D = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid, req_ready, req_src, rsp_valid, rsp_ready, rsp_eq;
  logic [7:0]     req_ctrl;
  logic [2*D-1:0] req_op1, req_imm, req_reg, rsp_data;
  logic           alusrc, eq;
  logic [3:0]     aluctrl;
  logic [D-1:0]   aluop1, immop, regop2, aluout, op2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.D_WIDTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl), .req_src(req_src),
    .req_op1(req_op1), .req_imm(req_imm), .req_reg(req_reg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_eq(rsp_eq),
    .alusrc(alusrc), .aluctrl(aluctrl), .aluop1(aluop1), .immop(immop), .regop2(regop2),
    .aluout(aluout), .eq(eq)
  );

  // alu stub: 0 add, 1 sub, 2 signed less-than, 3 unsigned less-than, else and; eq = result nonzero
  always_comb begin
    op2 = alusrc ? immop : regop2;
    case (aluctrl)
      4'b0000: aluout = aluop1 + op2;
      4'b0001: aluout = aluop1 - op2;
      4'b0010: aluout = {31'd0, $signed(aluop1) < $signed(op2)};
      4'b0011: aluout = {31'd0, aluop1 < op2};
      default: aluout = aluop1 & op2;
    endcase
    eq = (aluout != '0);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_req(input int i, input logic [3:0] ctrl, input logic src,
                         input logic [D-1:0] op1, input logic [D-1:0] imm, input logic [D-1:0] rg);
    req_ctrl[4*i +: 4] = ctrl;
    req_src[i]         = src;
    req_op1[D*i +: D]  = op1;
    req_imm[D*i +: D]  = imm;
    req_reg[D*i +: D]  = rg;
  endtask

  task automatic edge_after();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g;

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_ctrl = '0; req_src = '0; req_op1 = '0; req_imm = '0; req_reg = '0;
    edge_after();
    edge_after();
    check("reset rsp_valid", rsp_valid, 2'b00);
    check("reset rsp_data", rsp_data, 64'd0);
    check("reset rsp_eq", rsp_eq, 2'b00);
    check("reset req_ready", req_ready, 2'b00);
    @(negedge clk); rst = 1'b0;

    // tie: req0 adds 1+2, req1 subtracts 9-4
    set_req(0, 4'b0000, 1'b0, 32'd1, 32'd0, 32'd2);
    set_req(1, 4'b0001, 1'b0, 32'd9, 32'd0, 32'd4);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (FIXED || (k % 2 == 0)) ? 2'b01 : 2'b10;
      #1;
      check($sformatf("tie grant %0d", k), req_ready, exp_g);
      edge_after();
      check($sformatf("tie rsp_valid %0d", k), rsp_valid, exp_g);
      if (exp_g == 2'b01) check($sformatf("tie add %0d", k), rsp_data[D-1:0], 32'd3);
      else                check($sformatf("tie sub %0d", k), rsp_data[2*D-1:D], 32'd5);
      @(negedge clk);
    end
    req_valid = 2'b00;
    edge_after();
    check("drain rsp_valid", rsp_valid, 2'b00);

    // branch compare on req1: slt(-1,1)=1 then sltu(-1,1)=0
    @(negedge clk);
    set_req(1, 4'b0010, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    req_valid = 2'b10; rsp_ready = 2'b00;
    #1 check("slt grant", req_ready, 2'b10);
    edge_after();
    check("slt data", rsp_data[2*D-1:D], 32'd1);
    check("slt eq", rsp_eq[1], 1'b1);
    @(negedge clk);
    set_req(1, 4'b0011, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    rsp_ready = 2'b10;
    #1 check("sltu regrant", req_ready, 2'b10);
    edge_after();
    check("sltu data", rsp_data[2*D-1:D], 32'd0);
    check("sltu eq", rsp_eq[1], 1'b0);
    check("sltu valid", rsp_valid, 2'b10);

    // single op on req0: 5+7
    @(negedge clk);
    set_req(0, 4'b0000, 1'b0, 32'd5, 32'd0, 32'd7);
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1 check("single grant", req_ready, 2'b01);
    check("single aluop1", aluop1, 32'd5);
    edge_after();
    check("single valid", rsp_valid, 2'b11);
    check("single data", rsp_data[D-1:0], 32'd12);

    // backpressure: slot0 full and not drained -> only req1 may issue
    @(negedge clk);
    set_req(0, 4'b0000, 1'b1, 32'd5, 32'd100, 32'd7);
    set_req(1, 4'b0001, 1'b0, 32'd9, 32'd0, 32'd4);
    req_valid = 2'b11; rsp_ready = 2'b10;
    #1 check("bp grant", req_ready, 2'b10);
    edge_after();
    check("bp hold data0", rsp_data[D-1:0], 32'd12);
    check("bp data1", rsp_data[2*D-1:D], 32'd5);
    check("bp valid", rsp_valid, 2'b11);
    @(negedge clk);
    rsp_ready = 2'b11;
    #1 check("bp release grant", req_ready, 2'b01);
    edge_after();
    check("bp regrant valid", rsp_valid, 2'b01);
    check("bp imm data0", rsp_data[D-1:0], 32'd105);

    // fill both slots, then reset asynchronously mid-cycle
    @(negedge clk);
    req_valid = 2'b10; rsp_ready = 2'b00;
    edge_after();
    check("prefill valid", rsp_valid, 2'b11);
    @(negedge clk);
    req_valid = 2'b00; rst = 1'b1;
    #1;
    check("async rst valid", rsp_valid, 2'b00);
    check("async rst data", rsp_data, 64'd0);
    check("async rst eq", rsp_eq, 2'b00);
    check("async rst ready", req_ready, 2'b00);
    @(negedge clk); rst = 1'b0;

    // first tie after reset goes to requester 0
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1 check("post rst tie", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    edge_after();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
